// File: rtl/fetch_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_types (package)
// Description : Shared types and constants for the instruction fetch stage:
//               word type, {pc, instr} packet, FSM state encoding, PC step,
//               and a helper that word-aligns a PC.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_types;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_pkt_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    localparam word_t PC_STEP = 32'd4;

    // Force a PC onto a word boundary by clearing bits [1:0].
    function automatic word_t align_pc(input word_t addr);
        return addr & ~word_t'(32'h3);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_out_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_out_buf
// Description : One-entry registered valid/ready output buffer. A load takes
//               priority over draining, so a packet can be replaced in the
//               same cycle the previous one is accepted. Flush empties the
//               buffer on the next edge and overrides any load.
// Ports       : clk, reset_n      - clock, synchronous active-low reset
//               flush             - drop the held packet
//               load, load_pkt    - capture a new packet
//               ready             - downstream accepts when valid
//               valid, pkt        - buffered packet towards the queue
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_out_buf
    import fetch_types::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       flush,
    input  logic       load,
    input  fetch_pkt_t load_pkt,
    input  logic       ready,
    output logic       valid,
    output fetch_pkt_t pkt
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid <= 1'b0;
            pkt   <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pkt   <= load_pkt;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Owns the PC, issues one read at a
//               time to the instruction cache and pushes {pc, instr} packets
//               to the instruction queue. Redirects reload the PC and any
//               wrong-path response still in flight is discarded.
//               Optional macro FETCH_PERF_CNT_EN adds transfer and stall-cycle
//               performance counters.
// Ports       : clk, reset_n                - clock, sync active-low reset
//               imem_read, imem_address     - cache read request
//               imem_resp, imem_rdata       - cache read completion
//               valid_o, rdy_i, data_o      - packet handshake to the queue
//               redirect_i, redirect_pc_i   - PC change request
//               perf_fetched_o, perf_stall_o (FETCH_PERF_CNT_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_types::*;
#(
    parameter word_t RESET_PC = 32'h4000_0060
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    output logic        valid_o,
    input  logic        rdy_i,
    output logic [63:0] data_o,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetched_o,
    output logic [31:0] perf_stall_o,
`endif
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    fetch_state_e state, state_next;
    word_t        pc, pc_next;
    word_t        addr, addr_next;
    logic         req, req_next;
    logic         live;
    logic         load;
    logic         transfer;
    logic         free_now;
    logic         req_active;
    word_t        pc_inc;
    word_t        redirect_target;
    fetch_pkt_t   out_pkt;

    assign transfer        = valid_o && rdy_i;
    // Buffer is free for the next cycle if nothing new is loaded into it.
    assign free_now        = !valid_o || rdy_i;
    assign pc_inc          = pc + PC_STEP;
    assign redirect_target = align_pc(redirect_pc_i);

    // A freshly issued request is only shown to the cache when the buffer can
    // take its response; once the cache has seen it (live), it is held until
    // the response regardless of the buffer, because the cache cannot abort.
    assign req_active   = req && (live || free_now);
    assign imem_read    = req_active;
    assign imem_address = addr;

    always_comb begin
        state_next = state;
        pc_next    = pc;
        addr_next  = addr;
        req_next   = req;
        load       = 1'b0;

        case (state)
            FETCH: begin
                if (req_active) begin
                    if (imem_resp) begin
                        if (redirect_i) begin
                            // Wrong-path data: drop it, restart at the target.
                            pc_next   = redirect_target;
                            addr_next = redirect_target;
                            req_next  = 1'b1;
                        end else begin
                            load    = 1'b1;
                            pc_next = pc_inc;
                            if (free_now) begin
                                addr_next = pc_inc;
                                req_next  = 1'b1;
                            end else begin
                                req_next   = 1'b0;
                                state_next = STALL;
                            end
                        end
                    end else if (redirect_i) begin
                        pc_next    = redirect_target;
                        state_next = FLUSH;
                    end
                end else if (redirect_i) begin
                    // Nothing seen by the cache yet, so redirect immediately.
                    pc_next   = redirect_target;
                    addr_next = redirect_target;
                    req_next  = 1'b1;
                end else if (free_now) begin
                    addr_next = pc;
                    req_next  = 1'b1;
                end else begin
                    req_next   = 1'b0;
                    state_next = STALL;
                end
            end

            STALL: begin
                if (redirect_i) begin
                    pc_next    = redirect_target;
                    addr_next  = redirect_target;
                    req_next   = 1'b1;
                    state_next = FETCH;
                end else if (transfer) begin
                    addr_next  = pc;
                    req_next   = 1'b1;
                    state_next = FETCH;
                end
            end

            FLUSH: begin
                if (redirect_i) begin
                    pc_next = redirect_target;
                end
                if (imem_resp) begin
                    addr_next  = redirect_i ? redirect_target : pc;
                    req_next   = 1'b1;
                    state_next = FETCH;
                end
            end

            default: begin
                req_next   = 1'b0;
                state_next = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= FETCH;
            pc    <= RESET_PC;
            addr  <= '0;
            req   <= 1'b0;
            live  <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            addr  <= addr_next;
            req   <= req_next;
            live  <= req_active && !imem_resp;
        end
    end

    fetch_out_buf u_out_buf (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (redirect_i),
        .load     (load),
        .load_pkt ({pc, imem_rdata}),
        .ready    (rdy_i),
        .valid    (valid_o),
        .pkt      (out_pkt)
    );

    assign data_o = out_pkt;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_fetched_o <= '0;
            perf_stall_o   <= '0;
        end else begin
            if (transfer) begin
                perf_fetched_o <= perf_fetched_o + 32'd1;
            end
            if (state == STALL) begin
                perf_stall_o <= perf_stall_o + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit. Inputs are
//               driven on the falling edge and outputs checked 1 ns later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        valid_o;
    logic        rdy_i;
    logic [63:0] data_o;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_o;
    logic [31:0] perf_stall_o;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    fetch_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .imem_read     (imem_read),
        .imem_address  (imem_address),
        .imem_resp     (imem_resp),
        .imem_rdata    (imem_rdata),
        .valid_o       (valid_o),
        .rdy_i         (rdy_i),
        .data_o        (data_o),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched_o(perf_fetched_o),
        .perf_stall_o  (perf_stall_o),
`endif
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs at the falling edge, settle, then return.
    task automatic step(input logic resp, input logic [31:0] rdata, input logic rdy,
                        input logic redir, input logic [31:0] rpc);
        @(negedge clk);
        imem_resp     = resp;
        imem_rdata    = rdata;
        rdy_i         = rdy;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    endtask

    initial begin
        reset_n       = 1'b0;
        imem_resp     = 1'b0;
        imem_rdata    = '0;
        rdy_i         = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;

        // ---------------- reset ----------------
        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("rst_read",  {63'd0, imem_read}, 64'd0);
        chk("rst_addr",  {32'd0, imem_address}, 64'd0);
        chk("rst_valid", {63'd0, valid_o}, 64'd0);
        chk("rst_data",  data_o, 64'd0);

        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rel0_read", {63'd0, imem_read}, 64'd0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("rel1_read",  {63'd0, imem_read}, 64'd1);
        chk("rel1_addr",  {32'd0, imem_address}, 64'h4000_0060);
        chk("rel1_valid", {63'd0, valid_o}, 64'd0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("rel2_addr",  {32'd0, imem_address}, 64'h4000_0060);
        chk("rel2_valid", {63'd0, valid_o}, 64'd0);

        // ---------------- backpressure ----------------
        step(1'b1, 32'h13, 1'b0, 1'b0, 32'h0);
        chk("bp_resp_read", {63'd0, imem_read}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            chk("bp_stall_read",  {63'd0, imem_read}, 64'd0);
            chk("bp_stall_valid", {63'd0, valid_o}, 64'd1);
            chk("bp_stall_data",  data_o, 64'h4000_0060_0000_0013);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("bp_xfer_valid", {63'd0, valid_o}, 64'd1);
        chk("bp_xfer_read",  {63'd0, imem_read}, 64'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("bp_next_read",  {63'd0, imem_read}, 64'd1);
        chk("bp_next_addr",  {32'd0, imem_address}, 64'h4000_0064);
        chk("bp_next_valid", {63'd0, valid_o}, 64'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched", {32'd0, perf_fetched_o}, 64'd1);
        chk("perf_stall",   {32'd0, perf_stall_o}, 64'd5);
`endif

        // ---------------- streaming ----------------
        do_reset();
        step(1'b1, 32'h13, 1'b1, 1'b0, 32'h0);
        chk("st0_addr", {32'd0, imem_address}, 64'h4000_0060);
        chk("st0_read", {63'd0, imem_read}, 64'd1);
        step(1'b1, 32'h93, 1'b1, 1'b0, 32'h0);
        chk("st1_data", data_o, 64'h4000_0060_0000_0013);
        chk("st1_addr", {32'd0, imem_address}, 64'h4000_0064);
        step(1'b1, 32'h113, 1'b1, 1'b0, 32'h0);
        chk("st2_data", data_o, 64'h4000_0064_0000_0093);
        chk("st2_addr", {32'd0, imem_address}, 64'h4000_0068);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("st3_data",  data_o, 64'h4000_0068_0000_0113);
        chk("st3_valid", {63'd0, valid_o}, 64'd1);
        chk("st3_addr",  {32'd0, imem_address}, 64'h4000_006C);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("st4_valid", {63'd0, valid_o}, 64'd0);
        chk("st4_read",  {63'd0, imem_read}, 64'd1);

        // ---------------- redirect with request in flight ----------------
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h8000_0002);
        chk("rf0_addr", {32'd0, imem_address}, 64'h4000_006C);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("rf1_read", {63'd0, imem_read}, 64'd1);
        chk("rf1_addr", {32'd0, imem_address}, 64'h4000_006C);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("rf2_addr", {32'd0, imem_address}, 64'h4000_006C);
        step(1'b1, 32'hDEAD, 1'b1, 1'b0, 32'h0);
        chk("rf3_read", {63'd0, imem_read}, 64'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("rf4_valid", {63'd0, valid_o}, 64'd0);
        chk("rf4_addr",  {32'd0, imem_address}, 64'h8000_0000);

        // ---------------- redirect with simultaneous response ----------------
        step(1'b1, 32'h55, 1'b1, 1'b1, 32'h0000_0100);
        chk("rs0_addr", {32'd0, imem_address}, 64'h8000_0000);
        step(1'b1, 32'h77, 1'b0, 1'b0, 32'h0);
        chk("rs1_valid", {63'd0, valid_o}, 64'd0);
        chk("rs1_addr",  {32'd0, imem_address}, 64'h0000_0100);

        // ---------------- redirect out of STALL ----------------
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("rst2_data", data_o, 64'h0000_0100_0000_0077);
        chk("rst2_read", {63'd0, imem_read}, 64'd0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0200);
        chk("rst3_valid", {63'd0, valid_o}, 64'd1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("rst4_valid", {63'd0, valid_o}, 64'd0);
        chk("rst4_read",  {63'd0, imem_read}, 64'd1);
        chk("rst4_addr",  {32'd0, imem_address}, 64'h0000_0200);

        // ---------------- PC wrap at top of address space ----------------
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFF);
        step(1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("wr_flush_addr", {32'd0, imem_address}, 64'h0000_0200);
        step(1'b1, 32'hAA, 1'b1, 1'b0, 32'h0);
        chk("wr_addr", {32'd0, imem_address}, 64'hFFFF_FFFC);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("wr_data", data_o, 64'hFFFF_FFFC_0000_00AA);
        chk("wr_next_addr", {32'd0, imem_address}, 64'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
